// File: rtl/btn_defs.sv
// Shared definitions for the input-conditioning blocks: repeat FSM encoding
// and counter sizing helper.
package btn_defs;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   // Bits needed to count 0 .. n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debouncer, edge pulses,
// saturating hold counter and auto-repeat FSM.
module btn_channel
   import btn_defs::*;
#(
   parameter int unsigned DB_CYCLES     = 1_000_000,
   parameter int unsigned HOLD_WIDTH    = 16,
   parameter int unsigned REPEAT_DELAY  = 16,
   parameter int unsigned REPEAT_PERIOD = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  btn_in,
   input  logic                  tick,
   input  logic                  repeat_en,
   output logic                  btn_level,
   output logic                  btn_rise,
   output logic                  btn_fall,
   output logic                  btn_repeat,
   output logic [HOLD_WIDTH-1:0] hold_cnt
);

   localparam int unsigned DB_W    = cnt_width(DB_CYCLES);
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic             sync_q1, sync_q2;
   logic [DB_W-1:0]  db_cnt;
   logic             db_done, rise_ev, fall_ev;
   rpt_state_e       state_q, state_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_pulse;

   // Level toggles on the edge where the mismatch count would reach DB_CYCLES.
   assign db_done = (sync_q2 != btn_level) && (db_cnt == DB_LAST);
   assign rise_ev = db_done && !btn_level;
   assign fall_ev = db_done &&  btn_level;

   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_pulse = 1'b0;
      case (state_q)
         RPT_IDLE: begin
            if (rise_ev) begin
               rpt_pulse = 1'b1;
               rpt_cnt_d = '0;
               if (repeat_en) state_d = RPT_DELAY;
            end
         end
         RPT_DELAY: begin
            if (!btn_level || !repeat_en) begin
               state_d   = RPT_IDLE;
               rpt_cnt_d = '0;
            end else if (tick) begin
               if (rpt_cnt_q == DELAY_LAST) begin
                  rpt_pulse = 1'b1;
                  rpt_cnt_d = '0;
                  state_d   = RPT_REPEAT;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
         end
         RPT_REPEAT: begin
            if (!btn_level || !repeat_en) begin
               state_d   = RPT_IDLE;
               rpt_cnt_d = '0;
            end else if (tick) begin
               if (rpt_cnt_q == PERIOD_LAST) begin
                  rpt_pulse = 1'b1;
                  rpt_cnt_d = '0;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sync_q1    <= 1'b0;
         sync_q2    <= 1'b0;
         db_cnt     <= '0;
         btn_level  <= 1'b0;
         btn_rise   <= 1'b0;
         btn_fall   <= 1'b0;
         btn_repeat <= 1'b0;
         hold_cnt   <= '0;
         state_q    <= RPT_IDLE;
         rpt_cnt_q  <= '0;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
         if (db_done) begin
            btn_level <= ~btn_level;
            db_cnt    <= '0;
         end else if (sync_q2 != btn_level) begin
            db_cnt <= db_cnt + 1'b1;
         end else begin
            db_cnt <= '0;
         end
         btn_rise <= rise_ev;
         btn_fall <= fall_ev;
         // Rise wins over a coincident tick so a new press always starts at 0.
         if (rise_ev) begin
            hold_cnt <= '0;
         end else if (btn_level && tick && (hold_cnt != '1)) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
         state_q    <= state_d;
         rpt_cnt_q  <= rpt_cnt_d;
         btn_repeat <= rpt_pulse;
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one btn_channel per button, buses sliced here.
module btn_conditioner #(
   parameter int unsigned BTN_NUM       = 3,
   parameter int unsigned DB_CYCLES     = 1_000_000,
   parameter int unsigned HOLD_WIDTH    = 16,
   parameter int unsigned REPEAT_DELAY  = 16,
   parameter int unsigned REPEAT_PERIOD = 4
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [BTN_NUM-1:0]            btn_in,
   input  logic                          tick,
   input  logic [BTN_NUM-1:0]            repeat_en,
   output logic [BTN_NUM-1:0]            btn_level,
   output logic [BTN_NUM-1:0]            btn_rise,
   output logic [BTN_NUM-1:0]            btn_fall,
   output logic [BTN_NUM-1:0]            btn_repeat,
   output logic [BTN_NUM*HOLD_WIDTH-1:0] hold_cnt
);

   for (genvar i = 0; i < BTN_NUM; i++) begin : g_chan
      btn_channel #(
         .DB_CYCLES     (DB_CYCLES),
         .HOLD_WIDTH    (HOLD_WIDTH),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
         .sys_clk    (sys_clk),
         .sys_rst_n  (sys_rst_n),
         .btn_in     (btn_in[i]),
         .tick       (tick),
         .repeat_en  (repeat_en[i]),
         .btn_level  (btn_level[i]),
         .btn_rise   (btn_rise[i]),
         .btn_fall   (btn_fall[i]),
         .btn_repeat (btn_repeat[i]),
         .hold_cnt   (hold_cnt[i*HOLD_WIDTH +: HOLD_WIDTH])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expectations are scheduled by cycle
// when stimulus is applied and compared when that cycle is reached.
module tb_btn_conditioner;

   localparam int unsigned BN = 3;
   localparam int unsigned HW = 4;

   typedef enum int {K_LEVEL, K_RISE, K_FALL, K_REP, K_HOLD} kind_e;
   typedef struct {
      int unsigned at;
      kind_e       kind;
      int          ch;
      int          val;
      string       tag;
   } exp_t;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n;
   logic [BN-1:0]    btn_in;
   logic             tick;
   logic [BN-1:0]    repeat_en;
   logic [BN-1:0]    btn_level, btn_rise, btn_fall, btn_repeat;
   logic [BN*HW-1:0] hold_cnt;

   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb[$];

   btn_conditioner #(
      .BTN_NUM       (BN),
      .DB_CYCLES     (4),
      .HOLD_WIDTH    (HW),
      .REPEAT_DELAY  (3),
      .REPEAT_PERIOD (2)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .btn_in     (btn_in),
      .tick       (tick),
      .repeat_en  (repeat_en),
      .btn_level  (btn_level),
      .btn_rise   (btn_rise),
      .btn_fall   (btn_fall),
      .btn_repeat (btn_repeat),
      .hold_cnt   (hold_cnt)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int obs(input kind_e k, input int ch);
      case (k)
         K_LEVEL: return int'(btn_level[ch]);
         K_RISE:  return int'(btn_rise[ch]);
         K_FALL:  return int'(btn_fall[ch]);
         K_REP:   return int'(btn_repeat[ch]);
         default: return int'(hold_cnt[ch*HW +: HW]);
      endcase
   endfunction

   always @(negedge sys_clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            check_val($sformatf("%s ch%0d @%0d", sb[i].tag, sb[i].ch, cyc),
                      obs(sb[i].kind, sb[i].ch), sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic exp_at(input kind_e k, input int ch, input int unsigned at,
                         input int val, input string tag);
      exp_t e;
      e.at = at; e.kind = k; e.ch = ch; e.val = val; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic expect_pulse(input kind_e k, input int ch, input int unsigned at,
                               input string tag);
      exp_at(k, ch, at - 1, 0, tag);
      exp_at(k, ch, at,     1, tag);
      exp_at(k, ch, at + 1, 0, tag);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Tick is high for one cycle; its effect is visible on the following cycle.
   task automatic pulse_tick();
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned n0, s0, m0;
      sys_rst_n = 1'b0;
      btn_in    = '0;
      tick      = 1'b0;
      repeat_en = '0;
      step(3);
      for (int c = 0; c < int'(BN); c++) begin
         exp_at(K_LEVEL, c, cyc, 0, "rst_level");
         exp_at(K_RISE,  c, cyc, 0, "rst_rise");
         exp_at(K_FALL,  c, cyc, 0, "rst_fall");
         exp_at(K_REP,   c, cyc, 0, "rst_rep");
         exp_at(K_HOLD,  c, cyc, 0, "rst_hold");
      end
      step(1);
      sys_rst_n = 1'b1;
      step(2);

      // Clean press and release on channel 0, repeat disabled
      n0 = cyc;
      btn_in[0] = 1'b1;
      exp_at(K_LEVEL, 0, n0 + 5, 0, "a_level_pre");
      exp_at(K_LEVEL, 0, n0 + 6, 1, "a_level");
      expect_pulse(K_RISE, 0, n0 + 6, "a_rise");
      expect_pulse(K_REP,  0, n0 + 6, "a_rep");
      step(10);
      n0 = cyc;
      btn_in[0] = 1'b0;
      exp_at(K_LEVEL, 0, n0 + 5, 1, "a_level_hold");
      exp_at(K_LEVEL, 0, n0 + 6, 0, "a_level_rel");
      expect_pulse(K_FALL, 0, n0 + 6, "a_fall");
      step(10);

      // Glitch one cycle shorter than the debounce window on channel 1
      n0 = cyc;
      for (int unsigned c = n0; c <= n0 + 12; c++) begin
         exp_at(K_LEVEL, 1, c, 0, "b_level");
         exp_at(K_RISE,  1, c, 0, "b_rise");
      end
      btn_in[1] = 1'b1;
      step(3);
      btn_in[1] = 1'b0;
      step(12);

      // Hold channel 2 through saturation, release, tick on rise edge
      n0 = cyc;
      btn_in[2] = 1'b1;
      expect_pulse(K_RISE, 2, n0 + 6, "c_rise");
      exp_at(K_HOLD, 2, n0 + 6, 0, "c_hold0");
      step(7);
      for (int k = 1; k <= 20; k++) begin
         exp_at(K_HOLD, 2, cyc + 1, (k > 15) ? 15 : k, "c_hold");
         pulse_tick();
      end
      n0 = cyc;
      btn_in[2] = 1'b0;
      expect_pulse(K_FALL, 2, n0 + 6, "c_fall");
      exp_at(K_HOLD, 2, n0 + 7, 15, "c_keep");
      step(8);
      exp_at(K_HOLD, 2, cyc + 1, 15, "c_keep_tick");
      pulse_tick();
      n0 = cyc;
      btn_in[2] = 1'b1;
      exp_at(K_HOLD, 2, n0 + 5, 15, "c_pre_rise");
      expect_pulse(K_RISE, 2, n0 + 6, "c_rise2");
      exp_at(K_HOLD, 2, n0 + 6, 0, "c_rise_tick");
      step(5);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(3);
      btn_in[2] = 1'b0;
      step(10);

      // Auto-repeat on channel 0: pulses at rise and ticks 3,5,7,9
      repeat_en[0] = 1'b1;
      n0 = cyc;
      s0 = n0 + 7;
      for (int unsigned c = n0 + 5; c < s0 + 32; c++) begin
         int v;
         v = (c == n0 + 6 || c == s0 + 5 || c == s0 + 9 ||
              c == s0 + 13 || c == s0 + 17) ? 1 : 0;
         exp_at(K_REP, 0, c, v, "d_rep");
      end
      btn_in[0] = 1'b1;
      step(7);
      for (int k = 1; k <= 10; k++) pulse_tick();
      btn_in[0] = 1'b0;
      expect_pulse(K_FALL, 0, cyc + 6, "d_fall");
      step(8);
      pulse_tick();
      pulse_tick();
      repeat_en[0] = 1'b0;
      step(4);

      // Reset for one cycle mid-hold with tick present, button still held
      n0 = cyc;
      btn_in[2] = 1'b1;
      expect_pulse(K_RISE, 2, n0 + 6, "e_rise");
      step(8);
      pulse_tick();
      pulse_tick();
      exp_at(K_HOLD, 2, cyc, 2, "e_hold_pre");
      m0 = cyc;
      for (int c = 0; c < int'(BN); c++) begin
         exp_at(K_LEVEL, c, m0 + 1, 0, "e_rst_level");
         exp_at(K_RISE,  c, m0 + 1, 0, "e_rst_rise");
         exp_at(K_FALL,  c, m0 + 1, 0, "e_rst_fall");
         exp_at(K_REP,   c, m0 + 1, 0, "e_rst_rep");
         exp_at(K_HOLD,  c, m0 + 1, 0, "e_rst_hold");
      end
      exp_at(K_LEVEL, 2, m0 + 6, 0, "e_level_pre");
      expect_pulse(K_RISE, 2, m0 + 7, "e_rerise");
      exp_at(K_LEVEL, 2, m0 + 7, 1, "e_level");
      exp_at(K_HOLD, 2, m0 + 7, 0, "e_hold0");
      sys_rst_n = 1'b0;
      tick      = 1'b1;
      step(1);
      sys_rst_n = 1'b1;
      tick      = 1'b0;
      step(10);
      btn_in[2] = 1'b0;
      step(10);

      // Simultaneous press on channels 0 and 1, repeat disabled
      n0 = cyc;
      for (int unsigned c = n0; c <= n0 + 12; c++) begin
         int v;
         v = (c == n0 + 6) ? 1 : 0;
         exp_at(K_RISE, 0, c, v, "f_rise");
         exp_at(K_RISE, 1, c, v, "f_rise");
         exp_at(K_REP,  0, c, v, "f_rep");
         exp_at(K_REP,  1, c, v, "f_rep");
      end
      btn_in[1:0] = 2'b11;
      step(4);
      pulse_tick();
      pulse_tick();
      pulse_tick();
      step(2);
      btn_in[1:0] = 2'b00;
      step(12);

      check_val("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
